// File: rtl/muldiv_unit_pkg.sv
// Shared types and constants for the iterative RV32M multiply/divide unit.
package muldiv_unit_pkg;

  localparam int unsigned DEF_XLEN = 32;
  localparam int unsigned LATENCY  = DEF_XLEN + 1;

  typedef enum logic [2:0] {
    OpMul    = 3'b000,
    OpMulh   = 3'b001,
    OpMulhsu = 3'b010,
    OpMulhu  = 3'b011,
    OpDiv    = 3'b100,
    OpDivu   = 3'b101,
    OpRem    = 3'b110,
    OpRemu   = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    StIdle,
    StCalc,
    StFix
  } state_e;

  function automatic logic a_is_signed(input op_e op);
    return (op != OpMulhu) && (op != OpDivu) && (op != OpRemu);
  endfunction

  function automatic logic b_is_signed(input op_e op);
    return a_is_signed(op) && (op != OpMulhsu);
  endfunction

endpackage

// File: rtl/muldiv_unit_if.sv
// Request/response bundle between the control path and the multiply/divide unit.
interface muldiv_unit_if #(
  parameter int unsigned XLEN = 32
);
  logic            start;
  logic            flush;
  logic [2:0]      op;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic [4:0]      rd_in;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;
  logic [4:0]      rd_out;

  modport master (
    output start, flush, op, a, b, rd_in,
    input  busy, done, result, rd_out
  );

  modport slave (
    input  start, flush, op, a, b, rd_in,
    output busy, done, result, rd_out
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide: shift-add multiply and restoring divide sharing one
// 2*XLEN accumulator, fixed XLEN+1 cycle latency from acceptance to done.
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int unsigned XLEN  = DEF_XLEN,
  parameter int unsigned CNT_W = $clog2(XLEN)
) (
  input logic          clk,
  input logic          rst_n,
  muldiv_unit_if.slave bus
);

  state_e            r_state;
  logic [CNT_W-1:0]  r_cnt;
  op_e               r_op;
  logic [4:0]        r_rd;
  logic              r_neg;
  logic              r_rem_neg;
  logic [XLEN-1:0]   r_b;
  logic [2*XLEN-1:0] r_acc;
  logic              r_done;
  logic [XLEN-1:0]   r_result;
  logic [4:0]        r_rd_out;

  op_e               w_op;
  logic              w_a_neg;
  logic              w_b_neg;
  logic [XLEN-1:0]   w_a_mag;
  logic [XLEN-1:0]   w_b_mag;
  logic [XLEN-1:0]   w_hi;
  logic [XLEN-1:0]   w_lo;
  logic [XLEN:0]     w_add_a;
  logic [XLEN:0]     w_add_b;
  logic [XLEN+1:0]   w_sum;
  logic              w_ge;
  logic [2*XLEN-1:0] w_acc_next;
  logic [2*XLEN-1:0] w_prod;
  logic [XLEN-1:0]   w_fix;

  assign w_op    = op_e'(bus.op);
  assign w_a_neg = a_is_signed(w_op) & bus.a[XLEN-1];
  assign w_b_neg = b_is_signed(w_op) & bus.b[XLEN-1];
  assign w_a_mag = w_a_neg ? -bus.a : bus.a;
  assign w_b_mag = w_b_neg ? -bus.b : bus.b;

  assign w_hi = r_acc[2*XLEN-1:XLEN];
  assign w_lo = r_acc[XLEN-1:0];

  // One adder serves both algorithms: add for multiply, subtract (with borrow) for divide.
  always_comb begin
    w_add_a    = '0;
    w_add_b    = '0;
    w_sum      = '0;
    w_ge       = 1'b0;
    w_acc_next = r_acc;
    if (r_op[2]) begin
      w_add_a    = {w_hi, w_lo[XLEN-1]};
      w_add_b    = {1'b0, r_b};
      w_sum      = {1'b0, w_add_a} - {1'b0, w_add_b};
      w_ge       = ~w_sum[XLEN+1];
      w_acc_next = {(w_ge ? w_sum[XLEN-1:0] : w_add_a[XLEN-1:0]), w_lo[XLEN-2:0], w_ge};
    end else begin
      w_add_a    = {1'b0, w_hi};
      w_add_b    = w_lo[0] ? {1'b0, r_b} : '0;
      w_sum      = {1'b0, w_add_a} + {1'b0, w_add_b};
      w_acc_next = {w_sum[XLEN:0], w_lo[XLEN-1:1]};
    end
  end

  assign w_prod = r_neg ? -r_acc : r_acc;

  always_comb begin
    w_fix = '0;
    unique case (r_op)
      OpMul:                     w_fix = w_prod[XLEN-1:0];
      OpMulh, OpMulhsu, OpMulhu: w_fix = w_prod[2*XLEN-1:XLEN];
      OpDiv, OpDivu:             w_fix = r_neg ? -w_lo : w_lo;
      OpRem, OpRemu:             w_fix = r_rem_neg ? -w_hi : w_hi;
      default:                   w_fix = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= StIdle;
      r_cnt     <= '0;
      r_op      <= OpMul;
      r_rd      <= '0;
      r_neg     <= 1'b0;
      r_rem_neg <= 1'b0;
      r_b       <= '0;
      r_acc     <= '0;
      r_done    <= 1'b0;
      r_result  <= '0;
      r_rd_out  <= '0;
    end else begin
      r_done <= 1'b0;
      if (bus.flush) begin
        r_state <= StIdle;
      end else begin
        unique case (r_state)
          StIdle: begin
            if (bus.start) begin
              r_op      <= w_op;
              r_rd      <= bus.rd_in;
              // b == 0 keeps the raw all-ones quotient / dividend remainder unsigned-correct.
              r_neg     <= (w_a_neg ^ w_b_neg) & (|bus.b);
              r_rem_neg <= w_a_neg;
              r_b       <= w_b_mag;
              r_acc     <= {{XLEN{1'b0}}, w_a_mag};
              r_cnt     <= '0;
              r_state   <= StCalc;
            end
          end
          StCalc: begin
            r_acc <= w_acc_next;
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == CNT_W'(XLEN - 1)) begin
              r_state <= StFix;
            end
          end
          StFix: begin
            r_result <= w_fix;
            r_rd_out <= r_rd;
            r_done   <= 1'b1;
            r_state  <= StIdle;
          end
          default: r_state <= StIdle;
        endcase
      end
    end
  end

  assign bus.busy   = (r_state != StIdle);
  assign bus.done   = r_done;
  assign bus.result = r_result;
  assign bus.rd_out = r_rd_out;

endmodule
